// File: rtl/mips_pkg.sv
// Shared constants, opcode helpers and FSM state type for the MEM/WB stage.
package mips_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned REG_W     = 3;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned FLAG_W    = 2;
    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);

    localparam logic [OP_W-1:0] OP_LD      = 6'b010100;
    localparam logic [OP_W-1:0] OP_ST      = 6'b010101;
    localparam logic [1:0]      CTRL_CLASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_RD = 2'd1,
        LOAD_WB = 2'd2
    } state_t;

    // Control-class ops (branches/jumps) never write back.
    function automatic logic is_ctrl(input logic [OP_W-1:0] op);
        return op[OP_W-1 -: 2] == CTRL_CLASS;
    endfunction

endpackage

// File: rtl/mem_wb_block_data_mem.sv
// 256x16 data memory: synchronous write, registered read, contents not reset.
module data_mem
    import mips_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/mem_wb_block.sv
// MEM/WB stage: ALU writeback, stores, and two-cycle loads from local data memory.
// Optional held-flags register and flag_q port are enabled by defining FLAG_HOLD_EN.
module mem_wb_block
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [OP_W-1:0]   op_dec,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] DM_data,
    input  logic [FLAG_W-1:0] flag_ex,
    output logic              ready_out,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data
`ifdef FLAG_HOLD_EN
    ,
    output logic [FLAG_W-1:0] flag_q
`endif
);

    state_t            r_state;
    logic [REG_W-1:0]  r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_accept;
    logic              w_is_ld;
    logic              w_is_st;
    logic              w_is_alu;

    assign w_accept = valid_in & ready_out;
    assign w_is_ld  = (op_dec == OP_LD);
    assign w_is_st  = (op_dec == OP_ST);
    assign w_is_alu = !w_is_ld && !w_is_st && !is_ctrl(op_dec);

    // Reads happen only in LOAD_RD, so a store one cycle ahead of a load is already visible.
    data_mem u_data_mem (
        .i_clk   (clk),
        .i_we    (w_accept & w_is_st),
        .i_waddr (ans_ex[ADDR_W-1:0]),
        .i_wdata (DM_data),
        .i_re    (r_state == LOAD_RD),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_rd      <= '0;
            r_addr    <= '0;
            ready_out <= 1'b1;
            wb_en     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            wb_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && w_is_ld) begin
                        r_rd      <= rd_in;
                        r_addr    <= ans_ex[ADDR_W-1:0];
                        r_state   <= LOAD_RD;
                        ready_out <= 1'b0;
                    end else if (w_accept && w_is_alu) begin
                        wb_en   <= (rd_in != '0);
                        wb_rd   <= rd_in;
                        wb_data <= ans_ex;
                    end
                end
                LOAD_RD: begin
                    r_state <= LOAD_WB;
                end
                LOAD_WB: begin
                    r_state   <= IDLE;
                    ready_out <= 1'b1;
                    wb_en     <= (r_rd != '0);
                    wb_rd     <= r_rd;
                    wb_data   <= w_rdata;
                end
                default: begin
                    r_state   <= IDLE;
                    ready_out <= 1'b1;
                end
            endcase
        end
    end

`ifdef FLAG_HOLD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q <= '0;
        end else if (w_accept && w_is_alu) begin
            flag_q <= flag_ex;
        end
    end
`else
    logic w_unused_flags;
    assign w_unused_flags = ^flag_ex;
`endif

endmodule

// File: tb/tb_mem_wb_block.sv
// Self-checking bench for mem_wb_block: directed vector table, reset-in-load sequence, random vs model.
module tb_mem_wb_block;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [5:0]  op_dec;
    logic [2:0]  rd_in;
    logic [15:0] ans_ex;
    logic [15:0] DM_data;
    logic [1:0]  flag_ex;
    logic        ready_out;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
`ifdef FLAG_HOLD_EN
    logic [1:0]  flag_q;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_wb_block dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .op_dec    (op_dec),
        .rd_in     (rd_in),
        .ans_ex    (ans_ex),
        .DM_data   (DM_data),
        .flag_ex   (flag_ex),
        .ready_out (ready_out),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
`ifdef FLAG_HOLD_EN
        ,
        .flag_q    (flag_q)
`endif
    );

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [2:0]  rd;
        logic [15:0] ans;
        logic [15:0] dm;
        logic [1:0]  fl;
        logic        e_rdy;
        logic        e_en;
        logic [2:0]  e_rd;
        logic [15:0] e_data;
        logic [1:0]  e_fl;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [2:0] rd,
                                input logic [15:0] ans, input logic [15:0] dm, input logic [1:0] fl,
                                input logic e_rdy, input logic e_en, input logic [2:0] e_rd,
                                input logic [15:0] e_data, input logic [1:0] e_fl);
        vec_t t;
        t.v = v; t.op = op; t.rd = rd; t.ans = ans; t.dm = dm; t.fl = fl;
        t.e_rdy = e_rdy; t.e_en = e_en; t.e_rd = e_rd; t.e_data = e_data; t.e_fl = e_fl;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [2:0] rd,
                         input logic [15:0] ans, input logic [15:0] dm, input logic [1:0] fl);
        valid_in = v; op_dec = op; rd_in = rd; ans_ex = ans; DM_data = dm; flag_ex = fl;
    endtask

    task automatic chk_flags(input string nm, input logic [1:0] exp);
`ifdef FLAG_HOLD_EN
        chk(nm, 16'(flag_q), 16'(exp));
`else
        if (exp === 2'bxx) $display("unreachable %s", nm);
`endif
    endtask

    // Reference model state: memory image plus a countdown for an in-flight load.
    logic [15:0] m_mem [256];
    bit          m_known [256];
    int          m_pend;
    logic [2:0]  m_ld_rd;
    logic [15:0] m_ld_data;
    bit          m_ld_known;
    logic        m_en;
    logic [2:0]  m_rd;
    logic [15:0] m_data;
    bit          m_data_known;
    logic [1:0]  m_flag;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 6'd0, 3'd0, 16'h0, 16'h0, 2'b00);
        tick();
        tick();
        chk("reset_wb_en",   16'(wb_en),     16'd0);
        chk("reset_wb_rd",   16'(wb_rd),     16'd0);
        chk("reset_wb_data", wb_data,        16'h0000);
        chk("reset_ready",   16'(ready_out), 16'd1);
        chk_flags("reset_flag_q", 2'b00);
        reset = 1'b0;

        tbl[0]  = mk(1, 6'b000000, 3'd3, 16'h0000, 16'h0000, 2'b11, 1, 1, 3'd3, 16'h0000, 2'b11);
        tbl[1]  = mk(1, 6'b010101, 3'd1, 16'h0008, 16'hBEEF, 2'b01, 1, 0, 3'd3, 16'h0000, 2'b11);
        tbl[2]  = mk(1, 6'b010100, 3'd5, 16'h0008, 16'h0000, 2'b00, 0, 0, 3'd3, 16'h0000, 2'b11);
        tbl[3]  = mk(1, 6'b000011, 3'd2, 16'h2222, 16'h0000, 2'b10, 0, 0, 3'd3, 16'h0000, 2'b11);
        tbl[4]  = mk(1, 6'b000011, 3'd2, 16'h2222, 16'h0000, 2'b10, 1, 1, 3'd5, 16'hBEEF, 2'b11);
        tbl[5]  = mk(1, 6'b000011, 3'd2, 16'h2222, 16'h0000, 2'b10, 1, 1, 3'd2, 16'h2222, 2'b10);
        tbl[6]  = mk(0, 6'b000011, 3'd2, 16'h2222, 16'h0000, 2'b10, 1, 0, 3'd2, 16'h2222, 2'b10);
        tbl[7]  = mk(1, 6'b000001, 3'd0, 16'h1234, 16'h0000, 2'b01, 1, 0, 3'd0, 16'h1234, 2'b01);
        tbl[8]  = mk(1, 6'b110011, 3'd4, 16'hFFFF, 16'h0000, 2'b10, 1, 0, 3'd0, 16'h1234, 2'b01);
        tbl[9]  = mk(1, 6'b001010, 3'd7, 16'hABCD, 16'h0000, 2'b00, 1, 1, 3'd7, 16'hABCD, 2'b00);
        tbl[10] = mk(1, 6'b010101, 3'd7, 16'h1208, 16'h1111, 2'b11, 1, 0, 3'd7, 16'hABCD, 2'b00);
        tbl[11] = mk(1, 6'b010100, 3'd6, 16'h0008, 16'h0000, 2'b11, 0, 0, 3'd7, 16'hABCD, 2'b00);
        tbl[12] = mk(0, 6'b000000, 3'd0, 16'h0000, 16'h0000, 2'b00, 0, 0, 3'd7, 16'hABCD, 2'b00);
        tbl[13] = mk(0, 6'b000000, 3'd0, 16'h0000, 16'h0000, 2'b00, 1, 1, 3'd6, 16'h1111, 2'b00);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].ans, tbl[i].dm, tbl[i].fl);
            tick();
            chk($sformatf("vec%0d_ready", i), 16'(ready_out), 16'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_wb_en", i), 16'(wb_en),     16'(tbl[i].e_en));
            chk($sformatf("vec%0d_wb_rd", i), 16'(wb_rd),     16'(tbl[i].e_rd));
            chk($sformatf("vec%0d_wb_data", i), wb_data,      tbl[i].e_data);
            chk_flags($sformatf("vec%0d_flag_q", i), tbl[i].e_fl);
        end

        // Reset while a load sits in LOAD_RD, then reload the same address.
        drive(1, 6'b010101, 3'd1, 16'h0008, 16'hBEEF, 2'b00);
        tick();
        drive(1, 6'b010100, 3'd5, 16'h0008, 16'h0000, 2'b00);
        tick();
        chk("rstld_ready_low", 16'(ready_out), 16'd0);
        valid_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rstld_async_ready", 16'(ready_out), 16'd1);
        chk("rstld_async_wb_en", 16'(wb_en),     16'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rstld_idle%0d_wb_en", i), 16'(wb_en),     16'd0);
            chk($sformatf("rstld_idle%0d_ready", i), 16'(ready_out), 16'd1);
        end
        drive(1, 6'b010100, 3'd5, 16'h0008, 16'h0000, 2'b00);
        tick();
        chk("reld_ready0", 16'(ready_out), 16'd0);
        valid_in = 1'b0;
        tick();
        chk("reld_ready1", 16'(ready_out), 16'd0);
        chk("reld_no_en",  16'(wb_en),     16'd0);
        tick();
        chk("reld_wb_en",   16'(wb_en),     16'd1);
        chk("reld_wb_rd",   16'(wb_rd),     16'd5);
        chk("reld_wb_data", wb_data,        16'hBEEF);
        chk("reld_ready2",  16'(ready_out), 16'd1);

        // Random traffic against the model, starting from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 256; a++) begin
            m_mem[a] = 16'h0;
            m_known[a] = 1'b0;
        end
        m_mem[8] = 16'hBEEF;
        m_known[8] = 1'b1;
        m_pend = 0; m_en = 1'b0; m_rd = 3'd0; m_data = 16'h0; m_data_known = 1'b1; m_flag = 2'b00;
        m_ld_rd = 3'd0; m_ld_data = 16'h0; m_ld_known = 1'b0;

        for (int c = 0; c < 600; c++) begin
            int sel;
            logic [5:0] op;
            logic [7:0] addr;
            sel = $urandom_range(0, 9);
            if (sel < 2)       op = 6'b010100;
            else if (sel < 4)  op = 6'b010101;
            else if (sel == 4) op = {2'b11, 4'($urandom)};
            else begin
                op = {2'($urandom_range(0, 2)), 4'($urandom)};
                if (op == 6'b010100 || op == 6'b010101) op = 6'b000001;
            end
            drive(($urandom_range(0, 9) < 7), op, 3'($urandom), {8'($urandom), 8'($urandom_range(0, 15))},
                  16'($urandom), 2'($urandom));
            tick();

            m_en = 1'b0;
            addr = ans_ex[7:0];
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_en = (m_ld_rd != 3'd0);
                    m_rd = m_ld_rd;
                    m_data = m_ld_data;
                    m_data_known = m_ld_known;
                end
            end else if (valid_in) begin
                if (op_dec == 6'b010100) begin
                    m_pend = 2;
                    m_ld_rd = rd_in;
                    m_ld_data = m_mem[addr];
                    m_ld_known = m_known[addr];
                end else if (op_dec == 6'b010101) begin
                    m_mem[addr] = DM_data;
                    m_known[addr] = 1'b1;
                end else if (op_dec[5:4] != 2'b11) begin
                    m_en = (rd_in != 3'd0);
                    m_rd = rd_in;
                    m_data = ans_ex;
                    m_data_known = 1'b1;
                    m_flag = flag_ex;
                end
            end

            chk($sformatf("rnd%0d_ready", c), 16'(ready_out), 16'(m_pend == 0));
            chk($sformatf("rnd%0d_wb_en", c), 16'(wb_en),     16'(m_en));
            chk($sformatf("rnd%0d_wb_rd", c), 16'(wb_rd),     16'(m_rd));
            if (m_data_known) chk($sformatf("rnd%0d_wb_data", c), wb_data, m_data);
            chk_flags($sformatf("rnd%0d_flag_q", c), m_flag);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_block.md
MEM_WB_BLOCK -- requirements
Module: mem_wb_block

Interface
REQ-001 SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port valid_in  input  1  execution-stage result valid.
REQ-005 SHALL have port op_dec  input  6  decoded opcode accompanying the result.
REQ-006 SHALL have port rd_in  input  3  destination register index.
REQ-007 SHALL have port ans_ex  input  16  ALU result, or memory address for LD/ST.
REQ-008 SHALL have port DM_data  input  16  store data.
REQ-009 SHALL have port flag_ex  input  2  execution flags.
REQ-010 SHALL have port ready_out  output  1  block accepts a new op this cycle.
REQ-011 SHALL have port wb_en  output  1  register-file write strobe, one-cycle pulse.
REQ-012 SHALL have port wb_rd  output  3  register-file write index.
REQ-013 SHALL have port wb_data  output  16  register-file write data.
REQ-014 SHALL have port flag_q  output  2  held flags, present only under FLAG_HOLD_EN.

Function
REQ-015 SHALL accept an op on a rising edge when valid_in=1 and ready_out=1; valid_in while ready_out=0 SHALL be ignored, and upstream holds its inputs.
REQ-016 SHALL classify ops as follows: LD=6'b010100, ST=6'b010101, control class op_dec[5:4]=2'b11 (no writeback), all others ALU.
REQ-017 SHALL contain internal data memory of 256x16, addressed by ans_ex[7:0]; ans_ex[15:8] is ignored.
REQ-018 SHALL, for an ALU op accepted at edge k, register wb_en=1, wb_rd=rd_in, wb_data=ans_ex at edge k; the block stays in IDLE.
REQ-019 SHALL, for ST, write DM_data to mem[ans_ex[7:0]] at the accept edge with wb_en=0.
REQ-020 SHALL use FSM states IDLE, LOAD_RD and LOAD_WB: LD accept -> LOAD_RD; next edge -> LOAD_WB (read data registered); next edge -> IDLE with wb_en=1, wb_data=mem word, wb_rd=latched rd.
REQ-021 SHALL complete LD writeback at edge k+2; ready_out=1 only in IDLE, so it is low for exactly 2 cycles.
REQ-022 SHALL keep wb_en high for one cycle only; it is 0 whenever no writeback completes.
REQ-023 SHALL force wb_en=0 for any op with rd=0 (r0 hardwired); wb_rd and wb_data still update.
REQ-024 SHALL make an LD to the address written by the immediately preceding ST return the new data.
REQ-025 SHALL treat control-class ops as consumed with no state change and wb_en=0.

Reset
REQ-026 SHALL, on reset, drive wb_en=0, wb_rd=0, wb_data=0 and flag_q=0, set state to IDLE and make ready_out=1.
REQ-027 SHALL, if reset is asserted mid-load, drop the pending load with no writeback.
REQ-028 SHALL leave memory contents unchanged by reset.

Configuration
REQ-029 SHALL, with FLAG_HOLD_EN defined, provide port flag_q, loaded from flag_ex on each accepted ALU op and held on LD/ST/control ops.
REQ-030 SHALL, without FLAG_HOLD_EN, omit flag_q and its register, with flag_ex unused.

Structure
REQ-031 SHALL take opcode constants (LD, ST, control class), data width 16, register index width 3, memory depth 256 and the FSM state enum from shared package mips_pkg.
REQ-032 SHALL implement memory as sub-module data_mem, with synchronous write and registered read.

Verification
REQ-033 SHALL cover reset: assert reset -> wb_en=0, wb_data=0x0000, ready_out=1, flag_q=2'b00.
REQ-034 SHALL cover an ALU op: op=000000, ans_ex=0x0000, flag_ex=2'b11, rd=3 -> next cycle wb_en=1, wb_rd=3, wb_data=0x0000, flag_q=2'b11.
REQ-035 SHALL cover store then load: ST ans_ex=0x0008, DM_data=0xBEEF, then LD ans_ex=0x0008, rd=5 -> ready_out low 2 cycles, wb_en=1, wb_rd=5, wb_data=0xBEEF at edge k+2.
REQ-036 SHALL cover stall: ALU op rd=2 held valid during the LD -> ignored until ready_out=1, then accepted once, one wb_en pulse.
REQ-037 SHALL cover reset in LOAD_RD: reset pulse -> no wb_en, ready_out=1; re-LD 0x0008 -> 0xBEEF.
REQ-038 SHALL cover rd=0: ALU op rd=0, ans_ex=0x1234 -> wb_en stays 0.
